// File: rtl/mem_slave_resp_pkg.sv
// Shared types and widths for the data-memory responder.
// Imported by the interface, the array and the top.
package mem_resp_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_slave_resp_if.sv
// Request/response bus between a data-port requester
// and the memory responder.
interface mem_slave_resp_if;
  import mem_resp_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_read, mem_write,
    output mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_read, mem_write,
    input  mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_slave_resp_array.sv
// Single-port storage: one write or one read per cycle,
// read data registered and held until the next read.
module mem_array_1rw
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_slave_resp.sv
// Fixed-latency word memory responder with a one-shot
// committed-write event and a sticky protocol-error flag.
module mem_slave_resp
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_slave_resp_if.slave   bus,
  output logic              obs_wen,
  output logic [ADDR_W-1:0] obs_addr,
  output logic [DATA_W-1:0] obs_data,
  output logic              err
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req, accept, commit;
  logic              arr_we, arr_re;
  op_t               op_in, cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [DATA_W-1:0] rdata;

  assign req    = bus.mem_read | bus.mem_write;
  assign accept = (state == IDLE) && req;
  assign op_in  = bus.mem_write ? OP_WR : OP_RD;

  // With LATENCY=1 the commit edge is the accept edge,
  // so the live inputs stand in for the not-yet-loaded latches.
  assign cur_op    = (state == IDLE) ? op_in : op_q;
  assign cur_addr  = (state == IDLE) ? bus.mem_addr : addr_q;
  assign cur_wdata = (state == IDLE) ? bus.mem_wdata : wdata_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          cnt_nx   = LAT_M1;
          state_nx = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign commit = rst && (state != DONE) && (state_nx == DONE);
  assign arr_we = commit && (cur_op == OP_WR);
  assign arr_re = commit && (cur_op == OP_RD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        op_q    <= op_in;
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      obs_wen  <= 1'b0;
      obs_addr <= '0;
      obs_data <= '0;
      err      <= 1'b0;
    end else begin
      obs_wen <= arr_we;
      if (arr_we) begin
        obs_addr <= cur_addr;
        obs_data <= cur_wdata;
      end
      if (accept && bus.mem_read && bus.mem_write)
        err <= 1'b1;
    end
  end

  mem_array_1rw #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_arr (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .addr (cur_addr[DEPTH_LOG2-1:0]),
    .wdata(cur_wdata),
    .rdata(rdata)
  );

  assign bus.mem_rdata = rdata;
  assign bus.mem_ready = (state == DONE);

endmodule

// File: tb/tb_mem_slave_resp.sv
// Scoreboard bench: LATENCY=4 and LATENCY=1 responders,
// expectations queued at issue, checked by negedge monitors.
module tb_mem_slave_resp;
  import mem_resp_pkg::*;

  typedef struct {
    logic              wr;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
    int                due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  mem_slave_resp_if bus4();
  mem_slave_resp_if bus1();

  logic              ow4, ow1, er4, er1;
  logic [ADDR_W-1:0] oa4, oa1;
  logic [DATA_W-1:0] od4, od1;

  mem_slave_resp #(.DEPTH_LOG2(8), .LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .obs_wen(ow4), .obs_addr(oa4),
    .obs_data(od4), .err(er4)
  );

  mem_slave_resp #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .obs_wen(ow1), .obs_addr(oa1),
    .obs_data(od1), .err(er1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int k, input logic rdy,
                     input logic ow,
                     input logic [DATA_W-1:0] rd,
                     input logic [ADDR_W-1:0] oa,
                     input logic [DATA_W-1:0] od,
                     input logic er);
    exp_t e;
    if (ow && !rdy) chk("obs_wen_without_ready", 1, 0);
    if (!rdy) return;
    if ((k == 0 && sb0.size() == 0) ||
        (k == 1 && sb1.size() == 0)) begin
      chk("unexpected_ready", 1, 0);
      return;
    end
    e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
    chk("ready_cycle", cyc, e.due);
    chk("obs_wen", {31'd0, ow}, {31'd0, e.wr});
    if (e.wr) begin
      chk("obs_addr", {2'b0, oa}, {2'b0, e.addr});
      chk("obs_data", od, e.data);
    end else begin
      chk("mem_rdata", rd, e.rdata);
    end
    chk("err", {31'd0, er}, {31'd0, e.err});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, bus4.mem_ready, ow4, bus4.mem_rdata,
          oa4, od4, er4);
      mon(1, bus1.mem_ready, ow1, bus1.mem_rdata,
          oa1, od1, er1);
    end
  end

  task automatic drive(input int k, input logic wr,
                       input logic rd,
                       input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    if (k == 0) begin
      bus4.mem_write = wr; bus4.mem_read = rd;
      bus4.mem_addr  = a;  bus4.mem_wdata = d;
    end else begin
      bus1.mem_write = wr; bus1.mem_read = rd;
      bus1.mem_addr  = a;  bus1.mem_wdata = d;
    end
  endtask

  task automatic xact(input int k, input logic wr,
                      input logic rd,
                      input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d,
                      input logic [DATA_W-1:0] er,
                      input logic ee);
    exp_t e;
    logic seen;
    e.wr = wr; e.rdata = er; e.addr = a;
    e.data = d; e.err = ee;
    e.due = cyc + ((k == 0) ? 4 : 1);
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
    drive(k, wr, rd, a, d);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (k == 0) ? bus4.mem_ready : bus1.mem_ready;
    end
    if (!seen) chk("ready_timeout", 0, 1);
    drive(k, 0, 0, '0, '0);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus4.mem_ready}, 0);
    chk("rst_obs_wen", {31'd0, ow4}, 0);
    chk("rst_obs_addr", {2'b0, oa4}, 0);
    chk("rst_obs_data", od4, 0);
    chk("rst_rdata", bus4.mem_rdata, 0);
    chk("rst_err", {31'd0, er4}, 0);
    rst = 1'b1;
    dut4.u_arr.mem[3] = 32'h1111_2222;
    @(negedge clk);

    // abort a write to addr 3 while busy
    drive(0, 1, 0, 30'd3, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", {31'd0, bus4.mem_ready}, 0);
    chk("abort_obs_wen", {31'd0, ow4}, 0);
    drive(0, 0, 0, '0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xact(0, 0, 1, 30'd3, '0, 32'h1111_2222, 0);

    xact(0, 1, 0, 30'd0, 32'h6, '0, 0);
    xact(0, 0, 1, 30'd0, '0, 32'h6, 0);

    // held write: two completions, LATENCY+1 apart
    e.wr = 1; e.rdata = '0; e.addr = 30'd5;
    e.data = 32'hA5A5_0005; e.err = 0;
    e.due = cyc + 4; sb0.push_back(e);
    e.due = cyc + 9; sb0.push_back(e);
    drive(0, 1, 0, 30'd5, 32'hA5A5_0005);
    repeat (10) @(negedge clk);
    drive(0, 0, 0, '0, '0);
    repeat (3) @(negedge clk);

    xact(0, 1, 1, 30'd7, 32'h55, '0, 1);
    xact(0, 0, 1, 30'd7, '0, 32'h55, 1);
    chk("err_sticky", {31'd0, er4}, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("err_cleared", {31'd0, er4}, 0);
    @(negedge clk);

    xact(1, 1, 0, 30'h100, 32'h12, '0, 0);
    xact(1, 0, 1, 30'h0, '0, 32'h12, 0);

    repeat (6) @(negedge clk);
    chk("sb_drained", sb0.size() + sb1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
